// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst expander: validates one AW/AR-style command, then walks it beat by beat,
// producing address, index, byte-lane strobe and last flag for each data beat.
module axi4_burst_addr_gen #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter bit CHECK_4KB = 1'b1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic [ADDR_W-1:0]   beat_addr,
  output logic [7:0]          beat_idx,
  output logic [DATA_W/8-1:0] beat_strb,
  output logic                beat_last,
  output logic                err_valid,
  output logic [2:0]          err_code
);

  localparam int BPB      = DATA_W / 8;
  localparam int OFF_W    = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int SIZE_MAX = (BPB > 1) ? $clog2(BPB) : 0;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t            state_q, state_d;
  logic              ready_en_q;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_valid_q, err_valid_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [2:0]        cmd_err;
  logic              cmd_fire;

  // Address of beat n (n >= 1) of a burst; beat 0 is always the start address.
  // WRAP containers are powers of two because only legal lengths reach here.
  function automatic logic [ADDR_W-1:0] beat_address(
    input logic [ADDR_W-1:0] start,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst,
    input logic [7:0]        n
  );
    logic [ADDR_W-1:0] b_mask;
    logic [ADDR_W-1:0] c_mask;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] result;
    b_mask = (ADDR_W'(1) << size) - ADDR_W'(1);
    c_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    step   = ADDR_W'(n) << size;
    case (burst)
      BURST_FIXED: result = start;
      BURST_WRAP:  result = (start & ~c_mask) | ((start + step) & c_mask);
      default:     result = (start & ~b_mask) + step;
    endcase
    return result;
  endfunction

  // Legality of the offered command; 18 bits holds the worst-case 4KB span sum.
  always_comb begin
    logic [ADDR_W-1:0] b_mask;
    logic [17:0]       span;
    b_mask     = (ADDR_W'(1) << cmd_size) - ADDR_W'(1);
    span       = 18'(cmd_addr[11:0]) + ((18'(cmd_len) + 18'd1) << cmd_size)
               - 18'(cmd_addr & b_mask);
    cmd_err    = 3'b000;
    cmd_err[0] = (cmd_burst == BURST_WRAP) &&
                 (!(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((cmd_addr & b_mask) != '0));
    cmd_err[1] = CHECK_4KB && (cmd_burst != BURST_FIXED) && (span > 18'd4096);
    cmd_err[2] = (cmd_size > 3'(SIZE_MAX)) || (cmd_burst == BURST_RSVD);
  end

  assign cmd_ready = ready_en_q && (state_q == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    err_valid_d = 1'b0;
    err_code_d  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_err != 3'b000) begin
            err_valid_d = 1'b1;
            err_code_d  = cmd_err;
          end else begin
            state_d = ST_BURST;
            start_d = cmd_addr;
            len_d   = cmd_len;
            size_d  = cmd_size;
            burst_d = cmd_burst;
            idx_d   = 8'd0;
            addr_d  = cmd_addr;
          end
        end
      end
      ST_BURST: begin
        if (beat_ready) begin
          if (idx_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_q + 8'd1;
            addr_d = beat_address(start_q, len_q, size_q, burst_q, idx_q + 8'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ready_en_q keeps cmd_ready low for exactly one cycle after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      ready_en_q  <= 1'b0;
      start_q     <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'd0;
      idx_q       <= 8'd0;
      addr_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= 1'b1;
      start_q     <= start_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign beat_valid = (state_q == ST_BURST);
  assign beat_addr  = beat_valid ? addr_q : '0;
  assign beat_idx   = beat_valid ? idx_q : 8'd0;
  assign beat_last  = beat_valid && (idx_q == len_q);
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

  // Lanes run from the byte address up to the end of the size-aligned transfer.
  always_comb begin
    logic [ADDR_W-1:0] b_mask;
    logic [ADDR_W-1:0] aligned;
    int                lo;
    int                hi;
    b_mask    = (ADDR_W'(1) << size_q) - ADDR_W'(1);
    aligned   = addr_q & ~b_mask;
    lo        = int'(addr_q[OFF_W-1:0]) & (BPB - 1);
    hi        = (int'(aligned[OFF_W-1:0]) & (BPB - 1)) + (1 << size_q) - 1;
    beat_strb = '0;
    for (int i = 0; i < BPB; i++) begin
      if (beat_valid && (i >= lo) && (i <= hi)) beat_strb[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench for axi4_burst_addr_gen: directed vector table, hand-written
// reset/4KB sequences and randomized commands against an arithmetic reference model.
module tb_axi4_burst_addr_gen;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int BPB = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid, cmd_valid1;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          beat_ready;

  logic           cmd_ready, beat_valid, beat_last, err_valid;
  logic [AW-1:0]  beat_addr;
  logic [7:0]     beat_idx;
  logic [BPB-1:0] beat_strb;
  logic [2:0]     err_code;

  logic           cmd_ready1, beat_valid1, beat_last1, err_valid1;
  logic [AW-1:0]  beat_addr1;
  logic [7:0]     beat_idx1;
  logic [BPB-1:0] beat_strb1;
  logic [2:0]     err_code1;

  int checks = 0;
  int errors = 0;

  logic [63:0] obsAddr [16];
  logic [7:0]  obsStrb [16];
  int          obsCount;
  logic [2:0]  obsErr;

  always #5 aclk = ~aclk;

  axi4_burst_addr_gen #(.ADDR_W(AW), .DATA_W(DW), .CHECK_4KB(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_idx(beat_idx), .beat_strb(beat_strb), .beat_last(beat_last),
    .err_valid(err_valid), .err_code(err_code)
  );

  axi4_burst_addr_gen #(.ADDR_W(AW), .DATA_W(DW), .CHECK_4KB(1'b0)) dutNo4k (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid1), .beat_ready(beat_ready), .beat_addr(beat_addr1),
    .beat_idx(beat_idx1), .beat_strb(beat_strb1), .beat_last(beat_last1),
    .err_valid(err_valid1), .err_code(err_code1)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: straight from the addressing, strobe and legality rules.
  function automatic longint unsigned modelAddr(longint unsigned a, int len, int size, int burst, int n);
    longint unsigned b, c, base;
    b = 64'd1 << size;
    if (burst == 0) return a;
    if (burst == 1) return (n == 0) ? a : (a / b) * b + longint'(n) * b;
    c    = b * longint'(len + 1);
    base = (a / c) * c;
    return base + ((a - base + longint'(n) * b) % c);
  endfunction

  function automatic logic [7:0] modelStrb(longint unsigned a, int size);
    longint unsigned b, lo, hi;
    logic [7:0] s;
    b  = 64'd1 << size;
    lo = a % BPB;
    hi = ((a / b) * b) % BPB + b - 1;
    s  = 8'h00;
    for (int i = 0; i < BPB; i++) if (i >= lo && i <= hi) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [2:0] modelErr(longint unsigned a, int len, int size, int burst, bit chk4k);
    longint unsigned b;
    logic [2:0] e;
    b    = 64'd1 << size;
    e[0] = (burst == 2) && (!(len == 1 || len == 3 || len == 7 || len == 15) || (a % b) != 0);
    e[1] = chk4k && (burst != 0) && ((a % 4096) + longint'(len + 1) * b - (a % b)) > 4096;
    e[2] = (b > BPB) || (burst == 3);
    return e;
  endfunction

  task automatic sampleOut(input bit useNo4k, output logic bv, output logic [63:0] ba,
                           output logic [7:0] bi, output logic [7:0] bs, output logic bl,
                           output logic ev, output logic [2:0] ec, output logic cr);
    bv = useNo4k ? beat_valid1 : beat_valid;
    ba = useNo4k ? beat_addr1  : beat_addr;
    bi = useNo4k ? beat_idx1   : beat_idx;
    bs = useNo4k ? beat_strb1  : beat_strb;
    bl = useNo4k ? beat_last1  : beat_last;
    ev = useNo4k ? err_valid1  : err_valid;
    ec = useNo4k ? err_code1   : err_code;
    cr = useNo4k ? cmd_ready1  : cmd_ready;
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic sendCmd(input longint unsigned a, input int len, input int size, input int burst,
                         input bit useNo4k, output bit ok);
    logic rdy;
    cmd_addr  = a;
    cmd_len   = 8'(len);
    cmd_size  = 3'(size);
    cmd_burst = 2'(burst);
    if (useNo4k) cmd_valid1 = 1'b1; else cmd_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      rdy = useNo4k ? cmd_ready1 : cmd_ready;
      @(posedge aclk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    #1;
    cmd_valid  = 1'b0;
    cmd_valid1 = 1'b0;
    if (!ok) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input longint unsigned a, input int len, input int size, input int burst,
                               input int readyPct, input bit useNo4k);
    logic [2:0] expErr;
    logic bv, bl, ev, cr, r;
    logic [63:0] ba;
    logic [7:0] bi, bs;
    logic [2:0] ec;
    bit ok;
    int k, cyc;
    expErr   = modelErr(a, len, size, burst, !useNo4k);
    obsCount = 0;
    obsErr   = 3'b000;
    sendCmd(a, len, size, burst, useNo4k, ok);
    @(negedge aclk);
    if (!ok) return;
    sampleOut(useNo4k, bv, ba, bi, bs, bl, ev, ec, cr);
    if (expErr != 3'b000) begin
      checkOutput("err_valid_pulse", ev, 1);
      checkOutput("err_code", ec, expErr);
      checkOutput("no_beat_on_err", bv, 0);
      obsErr = ec;
      @(negedge aclk);
      sampleOut(useNo4k, bv, ba, bi, bs, bl, ev, ec, cr);
      checkOutput("err_pulse_end", ev, 0);
      checkOutput("no_beat_after_err", bv, 0);
      return;
    end
    checkOutput("err_quiet", ev, 0);
    checkOutput("first_beat_latency", bv, 1);
    k   = 0;
    cyc = 0;
    while (k <= len && cyc < 4000) begin
      sampleOut(useNo4k, bv, ba, bi, bs, bl, ev, ec, cr);
      if (!bv) begin
        checkOutput("beat_valid_held", bv, 1);
        break;
      end
      checkOutput("beat_addr", ba, modelAddr(a, len, size, burst, k));
      checkOutput("beat_idx", bi, k);
      checkOutput("beat_strb", bs, modelStrb(modelAddr(a, len, size, burst, k), size));
      checkOutput("beat_last", bl, (k == len));
      checkOutput("err_during_beat", ev, 0);
      if (k < 16) begin
        obsAddr[k] = ba;
        obsStrb[k] = bs;
      end
      r = ($urandom_range(99) < readyPct);
      beat_ready = r;
      @(negedge aclk);
      if (r) k++;
      cyc++;
    end
    beat_ready = 1'b0;
    if (cyc >= 4000) checkOutput("burst_timeout", k, len + 1);
    obsCount = k;
    sampleOut(useNo4k, bv, ba, bi, bs, bl, ev, ec, cr);
    checkOutput("idle_beat_valid", bv, 0);
    checkOutput("idle_cmd_ready", cr, 1);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          size;
    int          burst;
    logic [2:0]  expErr;
    int          expBeats;
    logic [63:0] expAddr [4];
    logic [7:0]  expStrb [4];
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0]  = '{64'h1000, 3, 3, 1, 3'b000, 4, '{64'h1000, 64'h1008, 64'h1010, 64'h1018}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[1]  = '{64'h2003, 2, 2, 1, 3'b000, 3, '{64'h2003, 64'h2004, 64'h2008, 64'h0}, '{8'h08, 8'hF0, 8'h0F, 8'h00}};
    tbl[2]  = '{64'h1008, 3, 2, 2, 3'b000, 4, '{64'h1008, 64'h100C, 64'h1000, 64'h1004}, '{8'h0F, 8'hF0, 8'h0F, 8'hF0}};
    tbl[3]  = '{64'h1008, 2, 2, 2, 3'b001, 0, '{64'h0, 64'h0, 64'h0, 64'h0}, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[4]  = '{64'h40,   4, 3, 0, 3'b000, 5, '{64'h40, 64'h40, 64'h40, 64'h40}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[5]  = '{64'hFF8,  1, 3, 1, 3'b010, 0, '{64'h0, 64'h0, 64'h0, 64'h0}, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[6]  = '{64'h100,  0, 4, 1, 3'b100, 0, '{64'h0, 64'h0, 64'h0, 64'h0}, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[7]  = '{64'h0,    0, 0, 3, 3'b100, 0, '{64'h0, 64'h0, 64'h0, 64'h0}, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[8]  = '{64'h1002, 3, 2, 2, 3'b001, 0, '{64'h0, 64'h0, 64'h0, 64'h0}, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[9]  = '{64'hFFC,  2, 2, 2, 3'b011, 0, '{64'h0, 64'h0, 64'h0, 64'h0}, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[10] = '{64'h7,    0, 0, 1, 3'b000, 1, '{64'h7, 64'h0, 64'h0, 64'h0}, '{8'h80, 8'h00, 8'h00, 8'h00}};
    tbl[11] = '{64'h2008, 1, 3, 2, 3'b000, 2, '{64'h2008, 64'h2000, 64'h0, 64'h0}, '{8'hFF, 8'hFF, 8'h00, 8'h00}};

    aresetn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_valid1 = 1'b0;
    cmd_addr   = '0;
    cmd_len    = 8'd0;
    cmd_size   = 3'd0;
    cmd_burst  = 2'd0;
    beat_ready = 1'b0;

    // Reset values, then the one-cycle cmd_ready hold-off after release.
    #2;
    checkOutput("rst_beat_valid", beat_valid, 0);
    checkOutput("rst_beat_addr", beat_addr, 0);
    checkOutput("rst_beat_idx", beat_idx, 0);
    checkOutput("rst_beat_strb", beat_strb, 0);
    checkOutput("rst_beat_last", beat_last, 0);
    checkOutput("rst_err_valid", err_valid, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checkOutput("post_rst_cmd_ready_low", cmd_ready, 0);
    @(negedge aclk);
    checkOutput("post_rst_cmd_ready_high", cmd_ready, 1);

    // Directed vector table with 60% beat_ready backpressure.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 60, 1'b0);
      checkOutput($sformatf("tbl%0d_err", i), obsErr, tbl[i].expErr);
      checkOutput($sformatf("tbl%0d_beats", i), obsCount, tbl[i].expBeats);
      for (int j = 0; j < 4 && j < tbl[i].expBeats; j++) begin
        checkOutput($sformatf("tbl%0d_addr%0d", i, j), obsAddr[j], tbl[i].expAddr[j]);
        checkOutput($sformatf("tbl%0d_strb%0d", i, j), obsStrb[j], tbl[i].expStrb[j]);
      end
    end

    // Same 4KB-crossing command on an instance that ignores crossings.
    applyStimulus(64'hFF8, 1, 3, 1, 100, 1'b1);
    checkOutput("no4k_beats", obsCount, 2);
    checkOutput("no4k_addr0", obsAddr[0], 64'hFF8);
    checkOutput("no4k_addr1", obsAddr[1], 64'h1000);
    checkOutput("no4k_strb1", obsStrb[1], 8'hFF);

    // Reset asserted mid-burst, right after beat 1 handshakes.
    begin
      bit ok;
      sendCmd(64'h3000, 7, 3, 1, 1'b0, ok);
      @(negedge aclk);
      checkOutput("mid_beat0_idx", beat_idx, 0);
      beat_ready = 1'b1;
      @(negedge aclk);
      checkOutput("mid_beat1_addr", beat_addr, 64'h3008);
      @(posedge aclk);
      #2;
      aresetn    = 1'b0;
      beat_ready = 1'b0;
      #1;
      checkOutput("mid_rst_beat_valid", beat_valid, 0);
      checkOutput("mid_rst_beat_addr", beat_addr, 0);
      checkOutput("mid_rst_beat_strb", beat_strb, 0);
      checkOutput("mid_rst_err_valid", err_valid, 0);
      checkOutput("mid_rst_cmd_ready", cmd_ready, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      checkOutput("mid_rel_cmd_ready_low", cmd_ready, 0);
      @(negedge aclk);
      checkOutput("mid_rel_cmd_ready_high", cmd_ready, 1);
      applyStimulus(64'h3000, 7, 3, 1, 50, 1'b0);
      checkOutput("after_rst_beats", obsCount, 8);
      checkOutput("after_rst_addr0", obsAddr[0], 64'h3000);
    end

    // Randomized commands against the reference model, 50% backpressure.
    for (int t = 0; t < 40; t++) begin
      longint unsigned a;
      int len, size, burst, sel;
      sel   = int'($urandom_range(9));
      burst = (sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
      size  = int'($urandom_range(4));
      len   = int'($urandom_range(15));
      if (burst == 2 && $urandom_range(3) != 0) begin
        sel = int'($urandom_range(3));
        len = (sel == 0) ? 1 : (sel == 1) ? 3 : (sel == 2) ? 7 : 15;
      end
      a = {$urandom, $urandom};
      if ($urandom_range(1) == 1) a = (a >> size) << size;
      applyStimulus(a, len, size, burst, 50, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
